mac_row_engine: RTL and testbench

Sequential multi-word multiply-accumulate row engine for the RSA decryption datapath. Computes R = A·b + Z + c0 for an NUM_WORDS-word operand A, a single-word multiplier b and an NUM_WORDS-word addend Z. A and Z are streamed in word-serially, least significant first, and the NUM_WORDS+1 result words come out as a stream. Generalises the single-word combinational multiply-add into a parametrised, flow-controlled row pass that the Montgomery multiplier loop issues once per outer iteration.

---
 rtl/mac_row_engine.sv | 138 +++++++++++++
 tb/tb_mac_row_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_row_engine.sv
// mac_row_engine: word-serial row pass R = A*b + Z + c0 over NUM_WORDS words.
// A and Z stream in least significant word first; NUM_WORDS+1 result words stream out,
// the last one being the final carry (flagged by r_last).
// Optional feature macro: MAC_CARRY_IN_EN adds the c_init port, which seeds the carry on start.
module mac_row_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] b_in,
`ifdef MAC_CARRY_IN_EN
    input  logic [DATA_WIDTH-1:0] c_init,
`endif
    output logic                  busy,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] a_word,
    input  logic [DATA_WIDTH-1:0] z_word,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_word,
    output logic                  r_last,
    output logic                  done
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(NUM_WORDS + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] CARRY = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  carry_reg;
    logic [CW-1:0] count;
    logic [PW-1:0] p;

    logic start_acc;
    logic in_hs;
    logic out_hs;
    logic carry_load;
    logic done_next;

    // Full-width product-sum; (2^W-1)^2 + 2(2^W-1) fits exactly in 2W bits.
    assign p = PW'(a_word) * PW'(b_reg) + PW'(z_word) + PW'(carry_reg);

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, input-ready and handshake decode
    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        start_acc  = 1'b0;
        in_hs      = 1'b0;
        carry_load = 1'b0;
        done_next  = 1'b0;
        out_hs     = r_valid && r_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_ready = !r_valid || r_ready;
                in_hs   = a_valid && (!r_valid || r_ready);
                if (in_hs && (count == LAST_IDX)) begin
                    state_next = CARRY;
                end
            end
            CARRY: begin
                // r_last marks that the carry word already sits in the output register
                carry_load = !r_last && (!r_valid || r_ready);
                if (out_hs && r_last) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, carry chain, word counter and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_reg     <= '0;
            carry_reg <= '0;
            count     <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_next;
            if (start_acc) begin
                b_reg <= b_in;
`ifdef MAC_CARRY_IN_EN
                carry_reg <= c_init;
`else
                carry_reg <= '0;
`endif
                count <= '0;
            end
            if (in_hs) begin
                r_word    <= p[W-1:0];
                carry_reg <= p[PW-1:W];
                r_valid   <= 1'b1;
                r_last    <= 1'b0;
                count     <= count + CW'(1);
            end else if (carry_load) begin
                r_word  <= carry_reg;
                r_valid <= 1'b1;
                r_last  <= 1'b1;
            end else if (out_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_row_engine.sv
// tb_mac_row_engine: table-driven rows with a scoreboard queue of expected result words.
// Build with or without MAC_CARRY_IN_EN; the carry-in vector's expectation follows the macro.
module tb_mac_row_engine;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    typedef struct packed {
        logic [W-1:0]         b;
        logic [W-1:0]         cin;
        logic [N-1:0][W-1:0]  a;
        logic [N-1:0][W-1:0]  z;
        logic [N:0][W-1:0]    r;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] b_in;
`ifdef MAC_CARRY_IN_EN
    logic [W-1:0] c_init;
`endif
    logic         busy;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_word;
    logic [W-1:0] z_word;
    logic         r_valid;
    logic         r_ready;
    logic [W-1:0] r_word;
    logic         r_last;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl [5];
    logic [W:0] exp_q [$];

    mac_row_engine #(.DATA_WIDTH(W), .NUM_WORDS(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .b_in    (b_in),
`ifdef MAC_CARRY_IN_EN
        .c_init  (c_init),
`endif
        .busy    (busy),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_word  (a_word),
        .z_word  (z_word),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_word  (r_word),
        .r_last  (r_last),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full row; optional 5-cycle output stall, in-flight start poke, or reset after abort_after inputs
    task automatic run_row(input int idx, input int stall_at, input bit poke_start, input int abort_after);
        vec_t       v;
        int         in_i;
        int         out_i;
        int         cyc;
        int         stall_left;
        int         last_cyc;
        bit         fin;
        logic [W-1:0] held_w;
        logic       held_l;
        logic [W:0] e;
        v = tbl[idx];
        in_i = 0; out_i = 0; cyc = 0; stall_left = 0; last_cyc = -1; fin = 0;
        held_w = '0; held_l = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        start = 1'b1;
        b_in  = v.b;
`ifdef MAC_CARRY_IN_EN
        c_init = v.cin;
`endif
        @(negedge clk);
        start = 1'b0;
        b_in  = '0;
`ifdef MAC_CARRY_IN_EN
        c_init = '0;
`endif
        #1;
        check("busy_after_start", 64'(busy), 64'd1);
        while (!fin && cyc < 200) begin
            if (cyc == stall_at) stall_left = 5;
            r_ready = (stall_left == 0);
            a_valid = (in_i < int'(N));
            a_word  = v.a[in_i % N];
            z_word  = v.z[in_i % N];
            start   = poke_start && (cyc == 2);
            b_in    = start ? 32'd7 : 32'd0;
            #1;
            if (abort_after > 0 && in_i == abort_after) begin
                reset = 1'b1;
                #1;
                check("rst_busy",    64'(busy),    64'd0);
                check("rst_a_ready", 64'(a_ready), 64'd0);
                check("rst_r_valid", 64'(r_valid), 64'd0);
                check("rst_r_last",  64'(r_last),  64'd0);
                check("rst_r_word",  64'(r_word),  64'd0);
                check("rst_done",    64'(done),    64'd0);
                a_valid = 1'b0;
                start   = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    check("rst_no_done", 64'(done), 64'd0);
                end
                exp_q.delete();
                return;
            end
            if (stall_left > 0) begin
                if (stall_left == 5) begin
                    held_w = r_word;
                    held_l = r_last;
                end else begin
                    check("stall_r_word", 64'(r_word), 64'(held_w));
                    check("stall_r_last", 64'(r_last), 64'(held_l));
                end
                check("stall_a_ready", 64'(a_ready), 64'd0);
                check("stall_r_valid", 64'(r_valid), 64'd1);
            end
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(r_word), 64'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("row%0d_word%0d", idx, out_i), 64'(r_word), 64'(e[W-1:0]));
                    check($sformatf("row%0d_last%0d", idx, out_i), 64'(r_last), 64'(e[W]));
                end
                out_i++;
                if (r_last) begin
                    fin = 1;
                    last_cyc = cyc;
                end
            end
            if (a_valid && a_ready) begin
                exp_q.push_back({1'b0, v.r[in_i]});
                if (in_i == int'(N) - 1) exp_q.push_back({1'b1, v.r[N]});
                in_i++;
            end
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            cyc++;
        end
        a_valid = 1'b0;
        start   = 1'b0;
        r_ready = 1'b1;
        if (!fin) begin
            check("row_timeout", 64'd0, 64'd1);
            return;
        end
        #1;
        check("done_pulse",   64'(done),  64'd1);
        check("busy_fall",    64'(busy),  64'd0);
        check("row_cycles",   64'(last_cyc), 64'(int'(N) + 1 + ((stall_at >= 0) ? 5 : 0)));
        check("row_words",    64'(out_i), 64'(N + 1));
        check("queue_empty",  64'(exp_q.size()), 64'd0);
        @(negedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        tbl[0] = '{b: 32'd2, cin: 32'd0,
                   a: {4{32'hFFFF_FFFF}}, z: '0,
                   r: {32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}};
        tbl[1] = '{b: 32'hFFFF_FFFF, cin: 32'd0,
                   a: {4{32'hFFFF_FFFF}}, z: {4{32'hFFFF_FFFF}},
                   r: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0}};
        tbl[2] = '{b: 32'd1, cin: 32'd0,
                   a: {32'd4, 32'd3, 32'd2, 32'd1}, z: {32'd40, 32'd30, 32'd20, 32'd10},
                   r: {32'd0, 32'd44, 32'd33, 32'd22, 32'd11}};
        tbl[3] = '{b: 32'h10, cin: 32'd0,
                   a: {32'h1, 32'hF000_0000, 32'h0, 32'h1000_0000}, z: '0,
                   r: {32'h0, 32'h1F, 32'h0, 32'h1, 32'h0}};
`ifdef MAC_CARRY_IN_EN
        tbl[4] = '{b: 32'd0, cin: 32'd5,
                   a: {4{32'h1234_5678}}, z: '0,
                   r: {32'd0, 32'd0, 32'd0, 32'd0, 32'd5}};
`else
        tbl[4] = '{b: 32'd0, cin: 32'd5,
                   a: {4{32'h1234_5678}}, z: '0,
                   r: {32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
`endif

        reset   = 1'b1;
        start   = 1'b0;
        b_in    = '0;
`ifdef MAC_CARRY_IN_EN
        c_init  = '0;
`endif
        a_valid = 1'b0;
        a_word  = '0;
        z_word  = '0;
        r_ready = 1'b1;
        #3;
        check("reset_busy",    64'(busy),    64'd0);
        check("reset_a_ready", 64'(a_ready), 64'd0);
        check("reset_r_valid", 64'(r_valid), 64'd0);
        check("reset_r_last",  64'(r_last),  64'd0);
        check("reset_r_word",  64'(r_word),  64'd0);
        check("reset_done",    64'(done),    64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_row(i, -1, 1'b0, 0);
        run_row(0, 2, 1'b0, 0);
        run_row(0, -1, 1'b1, 0);
        run_row(1, -1, 1'b0, 2);
        run_row(1, -1, 1'b0, 0);
        run_row(3, 3, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
